// File: rtl/tree_adder_feeder.sv
// rtl/tree_adder_feeder.sv - packs 2**N operand words into one flat vector with a golden sum
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid       operand word stream in
//   in_ready               high while the fill buffer can take a word
//   out_inps               packed vector, word k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   out_sum                unsigned sum of the words in out_inps
//   out_valid/out_ready    vector handshake out
//   fill_count             words currently held in the fill buffer (0..2**N)

module tree_adder_feeder #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH*(2**N)-1:0]  out_inps,
  output logic [DATA_WIDTH+N-1:0]       out_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N:0]                    fill_count
);

  localparam int WORDS = 2**N;
  localparam int VEC_W = DATA_WIDTH * WORDS;
  localparam int SUM_W = DATA_WIDTH + N;

  localparam logic [N:0] LAST_CNT = (N+1)'(WORDS - 1);
  localparam logic [N:0] FULL_CNT = (N+1)'(WORDS);

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [N:0]        fill_cnt_q, fill_cnt_d;
  logic [VEC_W-1:0]  buf_q, buf_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [VEC_W-1:0]  out_inps_q, out_inps_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic              out_valid_q, out_valid_d;

  // Buffer and accumulator as they would look with the incoming word
  // applied at the current slot; used both for a normal fill and for the
  // last-word handoff straight into the output register.
  logic [VEC_W-1:0]  buf_wr;
  logic [SUM_W-1:0]  acc_wr;

  logic accept;
  logic xfer;
  logic out_free;
  logic last_word;

  assign in_ready  = (state_q == ST_FILL);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign last_word = (fill_cnt_q == LAST_CNT);

  always_comb begin
    buf_wr = buf_q;
    buf_wr[fill_cnt_q[N-1:0]*DATA_WIDTH +: DATA_WIDTH] = in_data;
    acc_wr = acc_q + {{N{1'b0}}, in_data};
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    buf_d       = buf_q;
    acc_d       = acc_q;
    out_inps_d  = out_inps_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_FILL: begin
        // A transfer without a replacement empties the output register;
        // the last-word branch below overrides this for a handoff.
        if (xfer) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (!last_word) begin
            buf_d      = buf_wr;
            acc_d      = acc_wr;
            fill_cnt_d = fill_cnt_q + 1'b1;
          end else if (out_free) begin
            out_inps_d  = buf_wr;
            out_sum_d   = acc_wr;
            out_valid_d = 1'b1;
            fill_cnt_d  = '0;
            acc_d       = '0;
          end else begin
            // Output still occupied: park the complete vector in the
            // fill buffer and stop accepting until it can move.
            buf_d      = buf_wr;
            acc_d      = acc_wr;
            fill_cnt_d = FULL_CNT;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (xfer) begin
          out_inps_d  = buf_q;
          out_sum_d   = acc_q;
          out_valid_d = 1'b1;
          fill_cnt_d  = '0;
          acc_d       = '0;
          state_d     = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      buf_q       <= '0;
      acc_q       <= '0;
      out_inps_q  <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      buf_q       <= buf_d;
      acc_q       <= acc_d;
      out_inps_q  <= out_inps_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_inps   = out_inps_q;
  assign out_sum    = out_sum_q;
  assign out_valid  = out_valid_q;
  assign fill_count = fill_cnt_q;

endmodule
